// File: rtl/obi_mux2.sv
// obi_mux2: round-robin 2:1 OBI request arbiter with in-order response routing
module obi_mux2 #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    output logic        m0_err_o,
    input  logic        m1_req_i,
    input  logic [31:0] m1_addr_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic        m1_err_o,
    output logic        s_req_o,
    output logic        s_we_o,
    output logic [3:0]  s_be_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_wdata_o,
    input  logic        s_gnt_i,
    input  logic        s_rvalid_i,
    input  logic [31:0] s_rdata_i,
    input  logic        s_err_i,
    output logic        unexpected_rsp_o
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
    logic          ids [MAX_OUTSTANDING];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          last, lock, lock_id, sel, full, empty, push, pop;
    // Arbitration, address-phase mux and response routing are purely combinational
    always_comb begin
        full        = count == CW'(MAX_OUTSTANDING);
        empty       = count == '0;
        sel         = lock ? lock_id : (m0_req_i && m1_req_i) ? ~last : m1_req_i;
        s_req_o     = (sel ? m1_req_i : m0_req_i) && !full;
        s_we_o      = sel ? 1'b0 : m0_we_i;
        s_be_o      = sel ? 4'hF : m0_be_i;
        s_addr_o    = sel ? m1_addr_i : m0_addr_i;
        s_wdata_o   = sel ? 32'h0 : m0_wdata_i;
        push        = s_req_o && s_gnt_i;
        pop         = s_rvalid_i && !empty;
        m0_gnt_o    = push && !sel;
        m1_gnt_o    = push && sel;
        m0_rvalid_o = pop && !ids[rd_ptr];
        m1_rvalid_o = pop && ids[rd_ptr];
        m0_rdata_o  = s_rdata_i;
        m1_rdata_o  = s_rdata_i;
        m0_err_o    = s_err_i;
        m1_err_o    = s_err_i;
    end
    // Route FIFO of master IDs, pointers wrap modulo depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) ids[i] <= 1'b0;
        end else begin
            if (push) begin
                ids[wr_ptr] <= sel;
                wr_ptr      <= wr_ptr == PW'(MAX_OUTSTANDING - 1) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr == PW'(MAX_OUTSTANDING - 1) ? '0 : rd_ptr + PW'(1);
            if (push && !pop) count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end
    // Round-robin history, stall lock and sticky unexpected-response flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last             <= 1'b1;
            lock             <= 1'b0;
            lock_id          <= 1'b0;
            unexpected_rsp_o <= 1'b0;
        end else begin
            if (push) begin
                lock <= 1'b0;
                last <= sel;
            end else if (s_req_o) begin
                lock    <= 1'b1;
                lock_id <= sel;
            end
            if (s_rvalid_i && empty) unexpected_rsp_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_obi_mux2.sv
// tb_obi_mux2: directed stimulus with a response scoreboard for obi_mux2
module tb_obi_mux2;
    logic        clk = 0, rst_n = 0;
    logic        m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
    logic [3:0]  m0_be;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m1_addr, m1_rdata;
    logic        s_req, s_we, s_gnt, s_rvalid, s_err, unexp;
    logic [3:0]  s_be;
    logic [31:0] s_addr, s_wdata, s_rdata;
    int          errors = 0, checks = 0;
    logic [32:0] exp_q [$];
    logic [32:0] e;

    obi_mux2 #(.MAX_OUTSTANDING(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata), .m0_err_o(m0_err),
        .m1_req_i(m1_req), .m1_addr_i(m1_addr),
        .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata), .m1_err_o(m1_err),
        .s_req_o(s_req), .s_we_o(s_we), .s_be_o(s_be), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
        .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata), .s_err_i(s_err),
        .unexpected_rsp_o(unexp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        m0_req = 0; m0_we = 0; m0_be = 4'h3; m0_addr = 0; m0_wdata = 32'hDEAD_BEEF;
        m1_req = 0; m1_addr = 0;
        s_gnt = 0; s_rvalid = 0; s_rdata = 0; s_err = 0;
    endtask

    task automatic rsp(input logic id, input logic [31:0] d);
        s_rvalid = 1;
        s_rdata  = d;
        exp_q.push_back({id, d});
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        idle();
    endtask

    // Scoreboard monitor: every master rvalid must match the oldest expected response
    always @(negedge clk) begin
        if (rst_n && (m0_rvalid || m1_rvalid)) begin
            checks++;
            if (m0_rvalid && m1_rvalid) begin
                errors++;
                $display("FAIL rvalid_both: got m0=1 m1=1 expected one");
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rvalid_spurious: got m0=%b m1=%b expected none", m0_rvalid, m1_rvalid);
            end else begin
                e = exp_q.pop_front();
                if ({m1_rvalid, m1_rvalid ? m1_rdata : m0_rdata} !== e) begin
                    errors++;
                    $display("FAIL rvalid_route: got id=%b data=%h expected id=%b data=%h",
                             m1_rvalid, m1_rvalid ? m1_rdata : m0_rdata, e[32], e[31:0]);
                end
            end
        end
    end

    initial begin
        idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("reset_s_req", s_req, 0);
        chk("reset_gnt", {m0_gnt, m1_gnt}, 0);
        chk("reset_rvalid", {m0_rvalid, m1_rvalid}, 0);
        chk("reset_unexp", unexp, 0);
        next();

        // single m1 read
        m1_req = 1; m1_addr = 32'h100; s_gnt = 1;
        @(negedge clk);
        chk("t1_m1_gnt", m1_gnt, 1);
        chk("t1_m0_gnt", m0_gnt, 0);
        chk("t1_addr", s_addr, 32'h100);
        chk("t1_we_be", {s_we, s_be}, 5'h0F);
        next();
        rsp(1, 32'h13);
        @(negedge clk);
        chk("t1_m0_rvalid", m0_rvalid, 0);
        next();

        // both request for 6 cycles, alternating grants
        for (int k = 0; k <= 6; k++) begin
            if (k < 6) begin
                m0_req = 1; m0_addr = 32'h2000; m1_req = 1; m1_addr = 32'h3000; s_gnt = 1;
            end
            if (k > 0) rsp(1'((k - 1) % 2), 32'hA0 + k);
            @(negedge clk);
            if (k < 6) begin
                chk("t2_gnt", {m1_gnt, m0_gnt}, k % 2 ? 2'b10 : 2'b01);
                chk("t2_addr", s_addr, k % 2 ? 32'h3000 : 32'h2000);
            end
            next();
        end

        // stalled m1 request keeps selection locked against m0
        for (int k = 0; k <= 5; k++) begin
            if (k <= 3) begin m1_req = 1; m1_addr = 32'h400; end
            if (k >= 1 && k <= 4) begin m0_req = 1; m0_we = 1; m0_addr = 32'h500; end
            s_gnt = k >= 3 && k <= 4;
            if (k == 4) rsp(1, 32'h44);
            if (k == 5) rsp(0, 32'h55);
            @(negedge clk);
            if (k <= 3) chk("t3_addr_locked", s_addr, 32'h400);
            if (k <= 3) chk("t3_m1_gnt", m1_gnt, k == 3);
            if (k <= 3) chk("t3_m0_gnt", m0_gnt, 0);
            if (k == 4) chk("t3_m0_gnt_after", m0_gnt, 1);
            if (k == 4) chk("t3_addr_m0", {s_we, s_addr}, {1'b1, 32'h500});
            next();
        end

        // full FIFO gates the request until a response pops
        for (int k = 0; k <= 6; k++) begin
            if (k <= 4) begin m0_req = 1; m0_we = 1; m0_addr = 32'h600 + 4 * (k > 2 ? 2 : k); s_gnt = 1; end
            if (k == 3) rsp(0, 32'h61);
            if (k == 5) rsp(0, 32'h62);
            if (k == 6) rsp(0, 32'h63);
            @(negedge clk);
            if (k <= 4) chk("t4_s_req", s_req, k < 2 || k == 4);
            if (k <= 4) chk("t4_m0_gnt", m0_gnt, k < 2 || k == 4);
            next();
        end

        // simultaneous push and pop at count 1
        m0_req = 1; m0_addr = 32'h700; s_gnt = 1;
        @(negedge clk);
        chk("t5_m0_gnt", m0_gnt, 1);
        next();
        m1_req = 1; m1_addr = 32'h704; s_gnt = 1;
        rsp(0, 32'h71);
        @(negedge clk);
        chk("t5_m1_gnt", m1_gnt, 1);
        chk("t5_m0_rvalid", m0_rvalid, 1);
        next();
        rsp(1, 32'h72);
        @(negedge clk);
        chk("t5_m1_rvalid", m1_rvalid, 1);
        next();

        // unexpected response with empty FIFO
        s_rvalid = 1; s_rdata = 32'hBAD;
        @(negedge clk);
        chk("t6_no_rvalid", {m0_rvalid, m1_rvalid}, 0);
        chk("t6_unexp_before", unexp, 0);
        next();
        @(negedge clk);
        chk("t6_unexp_set", unexp, 1);
        next();
        @(negedge clk);
        chk("t6_unexp_sticky", unexp, 1);
        rst_n = 0;
        #1;
        chk("t6_unexp_reset", unexp, 0);
        next();
        rst_n = 1;

        chk("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/obi_mux2.md
# obi_mux2

Two-to-one OBI request arbiter merging the instruction-fetch port and the data-access port of `tinyriscv_core` onto a single shared memory/bus slave port. It sits directly downstream of the core's `instr_*` and `data_*` interfaces. It arbitrates address phases round-robin, holds the selection stable while a request waits for grant, and routes in-order responses back to the issuing master through an outstanding-transaction ID FIFO.

## Interface
- `MAX_OUTSTANDING`, 2: depth of the route FIFO, which is the maximum number of granted-but-unanswered transactions. Legal range 1..8.
- `clk`  in  1  core clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `m0_req_i`, `m0_we_i`, `m0_be_i[3:0]`, `m0_addr_i[31:0]`, `m0_wdata_i[31:0]`  in  master 0 (data port) address phase.
- `m0_gnt_o`, `m0_rvalid_o`  out  1  master 0 grant and response valid.
- `m0_rdata_o`  out  32  master 0 response data.
- `m0_err_o`  out  1  master 0 response error.
- `m1_req_i`, `m1_addr_i[31:0]`  in  master 1 (instruction port) address phase. Read-only: `we` is forced to 0 and `be` to 4'hF on the slave side.
- `m1_gnt_o`, `m1_rvalid_o`, `m1_rdata_o[31:0]`, `m1_err_o`  out  master 1 response channel.
- `s_req_o`, `s_we_o`, `s_be_o[3:0]`, `s_addr_o[31:0]`, `s_wdata_o[31:0]`  out  slave address phase.
- `s_gnt_i`, `s_rvalid_i`, `s_rdata_i[31:0]`, `s_err_i`  in  slave grant and response.
- `unexpected_rsp_o`  out  1  sticky flag, set when `s_rvalid_i` arrives with the FIFO empty.

## Operation
- OBI rules:
  - A master holds `req` and its address-phase signals stable until `gnt`.
  - The slave returns `rvalid` in order, no earlier than the cycle after the matching `gnt`.
- Route FIFO holds 1-bit master IDs, `MAX_OUTSTANDING` entries, with a count register of width clog2(`MAX_OUTSTANDING`+1).
  - Push: the selected ID is pushed on `s_req_o && s_gnt_i`.
  - Pop: on `s_rvalid_i`.
  - Push and pop in the same cycle leave the count unchanged. Pointers wrap modulo depth.
- Forwarding gate: when count == `MAX_OUTSTANDING`, `s_req_o`=0 and both `mN_gnt_o`=0, even if a pop occurs that same cycle. This keeps the path free of rvalid-to-gnt combinational logic.
- Arbitration, with state register `last` (ID of the last granted master) and `lock` plus `lock_id`:
  - If `lock`=1, the selection is `lock_id`.
  - Otherwise, if only one master requests, select it.
  - Otherwise, if both request, select the master not equal to `last`.
  - Slave address-phase outputs are a mux of the selected master. `s_req_o` = selected `req` && not full.
  - `gnt` goes only to the selected master: `mN_gnt_o` = `s_gnt_i` && `s_req_o` && sel==N.
  - If `s_req_o`=1 and `s_gnt_i`=0, set `lock`=1 and `lock_id`=sel next cycle.
  - On a grant, clear `lock` and set `last`=sel.
- Response routing:
  - `mN_rvalid_o` = `s_rvalid_i` && FIFO non-empty && head==N.
  - `rdata` and `err` are passed through to both masters unconditionally. They are only qualified by `rvalid`.
- Unexpected response: `s_rvalid_i` with an empty FIFO produces no master `rvalid` and sets `unexpected_rsp_o`, which stays set until reset.

## Timing
- Zero added latency. Address phase, grant and response are all combinational pass-through. Only the FIFO, `last` and `lock` are registered.
- Reset values:
  - Registers: count=0, pointers=0, `last`=1 (so m0 wins the first contention), `lock`=0, `unexpected_rsp_o`=0.
  - Outputs: all `rvalid`/`gnt`/`s_req_o` are 0 whenever the inputs are idle.
- Reset asserted mid-transaction: the FIFO is cleared immediately. Responses arriving afterwards count as unexpected, and the system must also reset the slave.
- Back-to-back: a master may be granted every cycle while the FIFO is not full. With `MAX_OUTSTANDING`=2 and a slave of 1-cycle rvalid latency, full throughput is sustained.

## Test plan
- Single m1 read at 0x0000_0100, slave gnt in the same cycle, rvalid 1 cycle later with rdata 0x00000013 -> `m1_gnt_o`=1 in cycle 0; `m1_rvalid_o`=1 and `m1_rdata_o`=0x00000013 in cycle 1; `m0_rvalid_o` stays 0.
- Both masters request every cycle for 6 cycles, slave always grants -> grants alternate m0,m1,m0,m1,m0,m1 (m0 first after reset); responses are routed to the matching masters in order.
- m1 requests, `s_gnt_i` held low 3 cycles, m0 raises req in cycle 1 -> `s_addr_o` stays m1's address until the grant in cycle 3; m0 is granted in cycle 4.
- `MAX_OUTSTANDING`=2, slave grants two m0 writes and withholds rvalid -> `s_req_o`=0 while full; the first rvalid pops, and the next cycle `s_req_o` resumes.
- Simultaneous grant (push m1) and rvalid (pop m0) at count=1 -> count stays 1; `m0_rvalid_o`=1 that cycle; the next rvalid goes to m1.
- `s_rvalid_i` pulse with the FIFO empty -> no master rvalid; `unexpected_rsp_o`=1 until `rst_n` is low, then 0.
